// File: rtl/stage_memory_pkg.sv
// Shared definitions for the memory stage: exception codes, funct3 encodings,
// FSM state constants and the MEM/WB register layout.
package stage_memory_pkg;

  localparam logic [2:0] EXC_NONE             = 3'd0;
  localparam logic [2:0] EXC_LOAD_MISALIGNED  = 3'd4;
  localparam logic [2:0] EXC_STORE_MISALIGNED = 3'd6;
  localparam logic [2:0] EXC_BUS_TIMEOUT      = 3'd5;

  localparam logic [2:0] INSTR_TYPE_NO_WB = 3'd7;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [31:0] alu_out;
    logic [4:0]  rd;
    logic        mem_to_reg;
    logic        write_enable;
    logic [2:0]  instr_type;
    logic [2:0]  exc;
    logic        complete;
  } memwb_t;

  // Undefined encodings (011/110/111) fall through to a word access.
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/stage_memory_load_store_align.sv
// Combinational store strobe/lane replication, load lane select/extension and
// alignment check. Misalignment detection is built only with MISALIGN_CHECK_EN.
module load_store_align
  import stage_memory_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  size;
  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size      = access_size(funct3);
    shifted   = rdata >> {addr_lo, 3'b000};
    byte_lane = shifted[7:0];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                      ((size == SZ_WORD) && (addr_lo != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: drives the ready/valid data port, stalls upstream while
// an access is outstanding and registers MEM/WB. Optional macro: MISALIGN_CHECK_EN.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_in_data,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_instr_type,
  input  logic [2:0]  in_exception_vector,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  input  logic        in_flush,
  output logic        out_dmem_req,
  output logic        out_dmem_we,
  output logic [31:0] out_dmem_addr,
  output logic [31:0] out_dmem_wdata,
  output logic [3:0]  out_dmem_wstrb,
  input  logic        in_dmem_ready,
  input  logic [31:0] in_dmem_rdata,
  output logic        out_stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [31:0] out_alu_out,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic [2:0]  out_instr_type,
  output logic [2:0]  out_exception_vector,
  output logic        out_complete
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        kill_q, kill_d;
  memwb_t      memwb_q, memwb_d;

  logic        is_mem, misaligned, access, timeout_hit, bubble;
  logic [3:0]  wstrb;
  logic [31:0] wdata, load_data;
  logic [2:0]  exc_code;

  load_store_align u_align (
    .addr_lo    (in_alu_out[1:0]),
    .funct3     (in_funct3),
    .store_data (in_mem_in_data),
    .rdata      (in_dmem_rdata),
    .wstrb      (wstrb),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // A flush seen in IDLE kills the access before it reaches the bus; once in
  // WAIT the bus transaction is already committed and must run to completion.
  assign is_mem = in_mem_read | in_mem_write;
  assign access = reset & in_valid & is_mem & (in_exception_vector == EXC_NONE) &
                  ~misaligned & ((state_q == ST_WAIT) | ~in_flush);
  assign timeout_hit = (state_q == ST_WAIT) & access & ~in_dmem_ready &
                       (count_q == TIMEOUT_LAST);

  assign out_stall      = access & ~in_dmem_ready & ~timeout_hit;
  assign out_dmem_req   = access & ~timeout_hit;
  assign out_dmem_we    = out_dmem_req & in_mem_write;
  assign out_dmem_addr  = {in_alu_out[31:2], 2'b00};
  assign out_dmem_wdata = wdata;
  assign out_dmem_wstrb = in_mem_write ? wstrb : 4'b0000;

  always_comb begin
    exc_code = in_exception_vector;
    if (in_exception_vector == EXC_NONE) begin
      if (is_mem & misaligned) begin
        exc_code = in_mem_write ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
      end else if (timeout_hit) begin
        exc_code = EXC_BUS_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    kill_d  = kill_q;
    case (state_q)
      ST_IDLE: begin
        count_d = 8'd0;
        kill_d  = 1'b0;
        if (access & ~in_dmem_ready) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (~access | in_dmem_ready | timeout_hit) begin
          state_d = ST_IDLE;
          count_d = 8'd0;
          kill_d  = 1'b0;
        end else begin
          count_d = count_q + 8'd1;
          kill_d  = kill_q | in_flush;
        end
      end
    endcase
  end

  assign bubble = out_stall | ~in_valid | in_flush | kill_q;

  always_comb begin
    memwb_d = '0;
    if (!bubble) begin
      memwb_d.valid        = 1'b1;
      memwb_d.data         = in_mem_read ? load_data : in_alu_out;
      memwb_d.alu_out      = in_alu_out;
      memwb_d.rd           = in_rd;
      memwb_d.mem_to_reg   = in_mem_to_reg;
      memwb_d.write_enable = in_write_enable & (exc_code == EXC_NONE);
      memwb_d.instr_type   = in_instr_type;
      memwb_d.exc          = exc_code;
      memwb_d.complete     = (in_instr_type != INSTR_TYPE_NO_WB);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      kill_q  <= 1'b0;
      memwb_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      kill_q  <= kill_d;
      memwb_q <= memwb_d;
    end
  end

  assign out_valid            = memwb_q.valid;
  assign out_data             = memwb_q.data;
  assign out_alu_out          = memwb_q.alu_out;
  assign out_rd               = memwb_q.rd;
  assign out_mem_to_reg       = memwb_q.mem_to_reg;
  assign out_write_enable     = memwb_q.write_enable;
  assign out_instr_type       = memwb_q.instr_type;
  assign out_exception_vector = memwb_q.exc;
  assign out_complete         = memwb_q.complete;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed scenarios plus randomized
// load/store/ALU traffic against a behavioural model. Honours MISALIGN_CHECK_EN.
module tb_stage_memory;
  import stage_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_out, in_mem_in_data, in_dmem_rdata;
  logic [2:0]  in_funct3, in_instr_type, in_exception_vector;
  logic [4:0]  in_rd;
  logic        in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable, in_flush;
  logic        in_dmem_ready;
  logic        out_dmem_req, out_dmem_we, out_stall;
  logic [31:0] out_dmem_addr, out_dmem_wdata, out_data, out_alu_out;
  logic [3:0]  out_dmem_wstrb;
  logic        out_valid, out_mem_to_reg, out_write_enable, out_complete;
  logic [4:0]  out_rd;
  logic [2:0]  out_instr_type, out_exception_vector;

  int n_checks = 0;
  int n_fail   = 0;

  stage_memory #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_out(in_alu_out),
    .in_mem_in_data(in_mem_in_data), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_instr_type(in_instr_type), .in_exception_vector(in_exception_vector),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
    .in_flush(in_flush), .out_dmem_req(out_dmem_req), .out_dmem_we(out_dmem_we),
    .out_dmem_addr(out_dmem_addr), .out_dmem_wdata(out_dmem_wdata),
    .out_dmem_wstrb(out_dmem_wstrb), .in_dmem_ready(in_dmem_ready),
    .in_dmem_rdata(in_dmem_rdata), .out_stall(out_stall), .out_valid(out_valid),
    .out_data(out_data), .out_alu_out(out_alu_out), .out_rd(out_rd),
    .out_mem_to_reg(out_mem_to_reg), .out_write_enable(out_write_enable),
    .out_instr_type(out_instr_type), .out_exception_vector(out_exception_vector),
    .out_complete(out_complete)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_alu_out = 0; in_mem_in_data = 0; in_funct3 = 0;
    in_rd = 0; in_instr_type = 0; in_exception_vector = 0;
    in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0; in_write_enable = 0;
    in_flush = 0; in_dmem_ready = 0; in_dmem_rdata = 0;
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
    in_valid = 1; in_mem_read = rd_op; in_mem_write = wr_op; in_funct3 = f3;
    in_alu_out = addr; in_mem_in_data = data; in_rd = 5'd3; in_instr_type = 3'd1;
    in_exception_vector = EXC_NONE; in_mem_to_reg = rd_op; in_write_enable = rd_op;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned off,
                                              input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * off)) & 32'hFF;
    h = ((off >= 2) ? (rdata >> 16) : rdata) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  // size in bytes implied by funct3
  function automatic int model_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    set_op(1, 0, F3_W, 32'h100, 32'h0);
    #3;
    n_checks++;
    if (out_dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %b want 0", out_dmem_req);
    end
    step();
    n_checks++;
    if ({out_valid, out_data, out_write_enable, out_exception_vector, out_complete} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b data=%h we=%b exc=%0d", out_valid, out_data,
                         out_write_enable, out_exception_vector);
    end
    n_checks++;
    if (out_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", out_stall);
    end
    idle_inputs();
    reset = 1;
    step();
  endtask

  task automatic test_store_byte();
    set_op(0, 1, F3_B, 32'h1003, 32'h0000_00AB);
    in_dmem_ready = 1;
    #1;
    n_checks++;
    if (out_dmem_wstrb !== 4'b1000 || out_dmem_wdata !== 32'hABAB_ABAB) begin
      n_fail++; $display("FAIL sb_lanes: strb=%b wdata=%h want 1000 abababab", out_dmem_wstrb, out_dmem_wdata);
    end
    n_checks++;
    if (out_dmem_req !== 1'b1 || out_dmem_we !== 1'b1 || out_dmem_addr !== 32'h1000 || out_stall !== 1'b0) begin
      n_fail++; $display("FAIL sb_req: req=%b we=%b addr=%h stall=%b want 1 1 1000 0", out_dmem_req,
                         out_dmem_we, out_dmem_addr, out_stall);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h1003 || out_exception_vector !== EXC_NONE) begin
      n_fail++; $display("FAIL sb_wb: valid=%b data=%h exc=%0d want 1 1003 0", out_valid, out_data, out_exception_vector);
    end
    $display("txn sb addr=00001003 strb=1000");
    idle_inputs();
    step();
  endtask

  task automatic test_load_byte();
    logic [2:0]  f3s [2];
    logic [31:0] exps[2];
    f3s[0] = F3_B;  exps[0] = 32'hFFFF_FF80;
    f3s[1] = F3_BU; exps[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      set_op(1, 0, f3s[i], 32'h1002, 32'h0);
      in_dmem_rdata = 32'h0080_0000;
      in_dmem_ready = 1;
      #1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exps[i] || out_write_enable !== 1'b1 || out_complete !== 1'b1) begin
        n_fail++; $display("FAIL load_byte_%0d: valid=%b data=%h we=%b cpl=%b want data %h", i, out_valid,
                           out_data, out_write_enable, out_complete, exps[i]);
      end
      $display("txn lb f3=%0d addr=00001002 data=%h", f3s[i], out_data);
      idle_inputs();
      step();
    end
  endtask

  task automatic test_wait_states();
    int stalls = 0;
    int valids = 0;
    logic [31:0] got = '0;
    for (int c = 0; c < 7; c++) begin
      if (c <= 3) begin
        set_op(1, 0, F3_W, 32'h3000, 32'h0);
        in_dmem_rdata = 32'h1234_5678;
      end else begin
        idle_inputs();
      end
      in_dmem_ready = (c == 3);
      #1;
      if (out_stall === 1'b1) stalls++;
      step();
      if (out_valid === 1'b1) begin
        valids++; got = out_data;
      end
    end
    n_checks++;
    if (stalls != 3) begin
      n_fail++; $display("FAIL wait_stall_cycles: got %0d want 3", stalls);
    end
    n_checks++;
    if (valids != 1 || got !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wait_result: valids=%0d data=%h want 1 12345678", valids, got);
    end
    $display("txn lw wait=3 data=%h", got);
  endtask

  task automatic test_timeout();
    int  req_cycles = 0;
    bit  dropped = 0;
    set_op(1, 0, F3_W, 32'h4000, 32'h0);
    for (int c = 0; c < 100 && !dropped; c++) begin
      #1;
      if (out_dmem_req === 1'b1) req_cycles++;
      else dropped = 1;
      step();
    end
    n_checks++;
    if (!dropped || req_cycles != 64) begin
      n_fail++; $display("FAIL timeout_req_cycles: dropped=%0d cycles=%0d want 64", dropped, req_cycles);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_exception_vector !== EXC_BUS_TIMEOUT || out_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL timeout_wb: valid=%b exc=%0d we=%b want 1 %0d 0", out_valid,
                         out_exception_vector, out_write_enable, EXC_BUS_TIMEOUT);
    end
    $display("txn lw timeout req_cycles=%0d", req_cycles);
    idle_inputs();
    step();
  endtask

  task automatic test_misalign();
    set_op(1, 0, F3_H, 32'h2001, 32'h0);
    in_dmem_rdata = 32'h1234_F00D;
    in_dmem_ready = 1;
    #1;
`ifdef MISALIGN_CHECK_EN
    n_checks++;
    if (out_dmem_req !== 1'b0 || out_stall !== 1'b0) begin
      n_fail++; $display("FAIL misalign_req: req=%b stall=%b want 0 0", out_dmem_req, out_stall);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_exception_vector !== EXC_LOAD_MISALIGNED || out_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL misalign_wb: valid=%b exc=%0d we=%b", out_valid, out_exception_vector, out_write_enable);
    end
`else
    n_checks++;
    if (out_dmem_req !== 1'b1 || out_dmem_addr !== 32'h2000) begin
      n_fail++; $display("FAIL misalign_req: req=%b addr=%h want 1 2000", out_dmem_req, out_dmem_addr);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_F00D || out_exception_vector !== EXC_NONE) begin
      n_fail++; $display("FAIL misalign_wb: valid=%b data=%h exc=%0d want 1 fffff00d 0", out_valid,
                         out_data, out_exception_vector);
    end
`endif
    $display("txn lh addr=00002001 exc=%0d", out_exception_vector);
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    int valids = 0;
    // flush while waiting: transaction completes, result is a bubble
    set_op(1, 0, F3_W, 32'h5000, 32'h0);
    for (int c = 0; c < 4; c++) begin
      in_flush = (c == 1);
      in_dmem_ready = (c == 3);
      #1;
      if (c == 1) begin
        n_checks++;
        if (out_dmem_req !== 1'b1) begin
          n_fail++; $display("FAIL flush_wait_req: got %b want 1", out_dmem_req);
        end
      end
      step();
      if (out_valid === 1'b1) valids++;
    end
    n_checks++;
    if (valids != 0) begin
      n_fail++; $display("FAIL flush_wait_valid: got %0d valid cycles want 0", valids);
    end
    $display("txn lw flushed in wait");
    idle_inputs();
    step();
    // flush in idle: no request, bubble
    set_op(1, 0, F3_W, 32'h5004, 32'h0);
    in_flush = 1; in_dmem_ready = 1;
    #1;
    n_checks++;
    if (out_dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_req: got %b want 0", out_dmem_req);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_wb: valid=%b we=%b want 0 0", out_valid, out_write_enable);
    end
    $display("txn lw flushed in idle");
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_wait();
    set_op(1, 0, F3_W, 32'h6000, 32'h0);
    step();
    step();
    reset = 0;
    #1;
    n_checks++;
    if (out_dmem_req !== 1'b0 || out_stall !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_wait: req=%b stall=%b valid=%b want 0 0 0", out_dmem_req,
                         out_stall, out_valid);
    end
    $display("txn lw reset mid wait");
    idle_inputs();
    step();
    reset = 1;
    step();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int unsigned kind, off, d, nbytes, cycles;
      logic [2:0]  f3, pre_exc, itype, exp_exc;
      logic [31:0] addr, data, rdata, exp_data, exp_wdata;
      logic [3:0]  exp_strb;
      bit          mis, acc, wen;
      logic [2:0]  load_f3s [6];
      load_f3s[0] = F3_B; load_f3s[1] = F3_H; load_f3s[2] = F3_W;
      load_f3s[3] = F3_BU; load_f3s[4] = F3_HU; load_f3s[5] = 3'b011;
      kind    = $urandom_range(0, 2);
      f3      = (kind == 0) ? load_f3s[$urandom_range(0, 5)] : 3'($urandom_range(0, 2));
      addr    = $urandom;
      data    = $urandom;
      rdata   = $urandom;
      d       = $urandom_range(0, 4);
      itype   = 3'($urandom_range(0, 7));
      wen     = (kind != 1) && ($urandom_range(0, 3) != 0);
      pre_exc = ($urandom_range(0, 7) == 0) ? 3'd2 : EXC_NONE;
      off     = addr % 4;
      nbytes  = model_bytes(f3);
`ifdef MISALIGN_CHECK_EN
      mis = (kind != 2) && (off % nbytes != 0);
`else
      mis = 0;
`endif
      acc     = (kind != 2) && (pre_exc == EXC_NONE) && !mis;
      exp_exc = (pre_exc != EXC_NONE) ? pre_exc :
                mis ? ((kind == 1) ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED) : EXC_NONE;
      exp_data = (kind == 0) ? model_load(f3, off, rdata) : addr;
      if (nbytes == 1) begin
        exp_strb = 4'(1 << off); exp_wdata = (data & 32'hFF) * 32'h0101_0101;
      end else if (nbytes == 2) begin
        exp_strb = (off >= 2) ? 4'b1100 : 4'b0011; exp_wdata = (data & 32'hFFFF) * 32'h0001_0001;
      end else begin
        exp_strb = 4'b1111; exp_wdata = data;
      end
      cycles = acc ? d + 1 : 1;

      in_valid = 1; in_mem_read = (kind == 0); in_mem_write = (kind == 1); in_funct3 = f3;
      in_alu_out = addr; in_mem_in_data = data; in_rd = 5'($urandom_range(0, 31));
      in_instr_type = itype; in_exception_vector = pre_exc; in_mem_to_reg = (kind == 0);
      in_write_enable = wen; in_dmem_rdata = rdata; in_flush = 0;
      for (int c = 0; c < int'(cycles); c++) begin
        in_dmem_ready = acc ? (c == int'(d)) : 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if (out_stall !== (acc && c < int'(d)) || out_dmem_req !== acc) begin
          n_fail++; $display("FAIL rnd_%0d_handshake: c=%0d stall=%b req=%b want req %b", t, c,
                             out_stall, out_dmem_req, acc);
        end
        if (acc && kind == 1 && c == int'(d)) begin
          n_checks++;
          if (out_dmem_wstrb !== exp_strb || out_dmem_wdata !== exp_wdata || out_dmem_addr !== (addr & ~32'h3)) begin
            n_fail++; $display("FAIL rnd_%0d_store: strb=%b wdata=%h addr=%h want %b %h %h", t,
                               out_dmem_wstrb, out_dmem_wdata, out_dmem_addr, exp_strb, exp_wdata, addr & ~32'h3);
          end
        end
        step();
        if (c < int'(cycles) - 1) begin
          n_checks++;
          if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_%0d_bubble: valid=%b want 0", t, out_valid);
          end
        end
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_data || out_exception_vector !== exp_exc ||
          out_write_enable !== (wen && exp_exc == EXC_NONE) || out_complete !== (itype != INSTR_TYPE_NO_WB) ||
          out_alu_out !== addr || out_rd !== in_rd) begin
        n_fail++; $display("FAIL rnd_%0d_wb: valid=%b data=%h exc=%0d we=%b cpl=%b want data %h exc %0d", t,
                           out_valid, out_data, out_exception_vector, out_write_enable, out_complete,
                           exp_data, exp_exc);
      end
      $display("txn %0d: kind=%0d f3=%0d addr=%h delay=%0d data=%h exc=%0d", t, kind, f3, addr,
               acc ? d : 0, out_data, out_exception_vector);
      idle_inputs();
      step();
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte();
    test_wait_states();
    test_timeout();
    test_misalign();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
# stage_memory

Fourth pipeline stage; sits between the EX/MEM and MEM/WB boundaries, consuming the ALU result, store data and control produced by the execute stage. It drives a ready/valid data-memory port, formats loads (sign/zero extension) and stores (byte strobes, lane replication), and stalls the upstream pipeline while an access is outstanding. Results, control and exception code are registered into MEM/WB for writeback and the ROB.

## Interface
- TIMEOUT, 64: cycles without `in_dmem_ready` before an access is abandoned (1..255).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  EX/MEM holds a live instruction.
- in_alu_out  in  32  effective address / ALU result.
- in_mem_in_data  in  32  store data (post-forwarding).
- in_funct3  in  3  access size/sign.
- in_rd, in_instr_type, in_exception_vector  in  5/3/3  passed through.
- in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable  in  1 each  control.
- in_flush  in  1  kill the instruction currently in this stage.
- out_dmem_req, out_dmem_we  out  1  request / write.
- out_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- out_dmem_wdata  out  32; out_dmem_wstrb  out  4.
- in_dmem_ready  in  1; in_dmem_rdata  in  32.
- out_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM.
- out_valid, out_data(32), out_alu_out(32), out_rd(5), out_mem_to_reg, out_write_enable, out_instr_type(3), out_exception_vector(3), out_complete  out  MEM/WB register.

## Operation
- access = in_valid & (in_mem_read|in_mem_write) & in_exception_vector==0 & ~misaligned.
- FSM IDLE/WAIT. IDLE: if access, assert req; if `in_dmem_ready` the same cycle, capture and stay IDLE, else go to WAIT. WAIT: hold req and all dmem outputs stable; on ready capture, go to IDLE; on counter==TIMEOUT-1, drop req, capture with `EXC_BUS_TIMEOUT`, go to IDLE.
- out_stall = access & ~in_dmem_ready & ~timeout_hit (combinational).
- Stores: SB wstrb=4'b0001<<addr[1:0], wdata=byte×4; SH wstrb=addr[1]?1100:0011, wdata=half×2; SW 1111.
- Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw. out_data = formatted load if mem_read else in_alu_out.
- Non-memory, pre-excepted, or misaligned instructions pass in one cycle, no request.
- Any exception (incoming, misaligned, timeout): out_write_enable forced 0, code in out_exception_vector.
- in_flush: in IDLE, capture a bubble (out_valid=0, write_enable=0). In WAIT, bus transaction completes (req not withdrawn) but captured result is a bubble.
- out_complete = out_valid & instr_type != `INSTR_TYPE_NO_WB`.
- funct3 values 011/110/111 on memory op: treated as LW/word.

## Timing
- Reset: state IDLE, counter 0, all MEM/WB outputs 0, out_dmem_req 0.
- Zero-wait memory: 1 cycle, no stall. N wait cycles: N stall cycles; result registered on the edge where ready=1.
- dmem outputs combinational from EX/MEM inputs (stable while stalled).
- While out_stall=1 MEM/WB loads a bubble each cycle.
- Reset mid-WAIT: request dropped immediately; memory side must tolerate abandonment.

## Configuration
- MISALIGN_CHECK_EN defined: half at odd address, word with addr[1:0]!=0 raise `EXC_LOAD_MISALIGNED`/`EXC_STORE_MISALIGNED`, no request.
- Undefined: no check; word accesses aligned down, half uses addr[1] only, addr[0] ignored.

## Structure
- Shared defines package: exception codes (`EXC_NONE`, `EXC_LOAD_MISALIGNED`, `EXC_STORE_MISALIGNED`, `EXC_BUS_TIMEOUT`), funct3 load/store encodings, FSM state enum.
- One sub-module: `load_store_align` (combinational strobe/lane/extension logic).

## Test plan
- SB to 0x1003 data 0x000000AB, ready same cycle -> wstrb 1000, wdata 0xABABABAB, no stall.
- LB at 0x1002, rdata 0x00800000 -> out_data 0xFFFFFF80; LBU -> 0x00000080.
- LW with ready after 3 cycles -> out_stall high exactly 3 cycles, out_data=rdata, out_valid 1 cycle.
- LW, ready never -> req drops after 64 cycles, out_exception_vector=EXC_BUS_TIMEOUT, write_enable 0.
- LH at 0x2001 with MISALIGN_CHECK_EN -> no req, EXC_LOAD_MISALIGNED; without -> req addr 0x2000, upper-half... lower half per addr[1]=0.
- in_flush during WAIT then ready -> out_valid 0; reset mid-WAIT -> req 0 immediately.
